ad9228_tx_emulator: RTL

- Transmit-side model of the AD9228 serial LVDS output. Serializes 12-bit per-channel samples into DDR-style bit streams with matching frame (FCO) and data (DCO) clocks.
- Used for loopback and bring-up of the on-board ADC readout path without a physical ADC. Also generates the AD9228 built-in test patterns.
- Outputs are single-ended; differential conversion is done by IO buffers outside this block.

---
 rtl/ad9228_pkg.sv | 24 ++
 rtl/ad9228_lane_ser.sv | 45 ++++
 rtl/ad9228_tx_emulator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ad9228_pkg.sv
// Shared constants and types for the AD9228 transmit emulator.
package ad9228_pkg;

  localparam int AD9228_BITS = 12;

  localparam logic [AD9228_BITS-1:0] AD9228_MIDSCALE = {1'b1, {(AD9228_BITS-1){1'b0}}};
  localparam logic [AD9228_BITS-1:0] AD9228_CHECK_A  = 12'hAAA;
  localparam logic [AD9228_BITS-1:0] AD9228_CHECK_B  = 12'h555;

  // Output pattern selected by the mode input, sampled at every frame load.
  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    MIDSCALE = 2'd1,
    CHECKER  = 2'd2,
    RAMP     = 2'd3
  } ad9228_mode_e;

  // Transmitter state: idle (pins quiet) or streaming frames.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ad9228_state_e;

endpackage

// File: rtl/ad9228_lane_ser.sv
// One serial lane: parallel-load shift register with a registered output bit.
// A load presents the first bit of the new word on the same edge; each shift
// presents the next bit. Clear parks the lane at 0 while the link is idle.
module ad9228_lane_ser #(
  parameter int BITS      = 12,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic            clear,
  input  logic [BITS-1:0] data,
  output logic            dout
);

  logic [BITS-1:0] sr_q;

  // Shift register and output bit; the word is consumed from one end.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr_q <= '0;
      dout <= 1'b0;
    end else if (load) begin
      if (LSB_FIRST) begin
        dout <= data[0];
        sr_q <= data >> 1;
      end else begin
        dout <= data[BITS-1];
        sr_q <= data << 1;
      end
    end else if (shift) begin
      if (LSB_FIRST) begin
        dout <= sr_q[0];
        sr_q <= sr_q >> 1;
      end else begin
        dout <= sr_q[BITS-1];
        sr_q <= sr_q << 1;
      end
    end
  end

endmodule

// File: rtl/ad9228_tx_emulator.sv
// AD9228 serial LVDS transmit model: frame FSM, bit counter, one-word hold
// register with valid/ready input, test-pattern generators, FCO/DCO
// generation and NUM_CHANNELS lane serializers. One serial bit per clk.
module ad9228_tx_emulator
  import ad9228_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int BITS         = AD9228_BITS,
  parameter bit LSB_FIRST    = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [NUM_CHANNELS*BITS-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [NUM_CHANNELS-1:0]      din,
  output logic                         fco,
  output logic                         dco,
  output logic                         frame_start,
  output logic                         underflow
);

  localparam int W     = NUM_CHANNELS * BITS;
  localparam int CNT_W = (BITS > 2) ? $clog2(BITS) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BITS / 2);

  // Per-lane patterns derived from BITS (equal to the package values at 12 bits).
  localparam logic [BITS-1:0] PAT_MID = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] PAT_A   = {(BITS/2){2'b10}};
  localparam logic [BITS-1:0] PAT_B   = {(BITS/2){2'b01}};

  ad9228_state_e    state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             load, shift, lane_clear;

  logic [W-1:0]     hold_q, last_q, frame_word;
  logic             hold_full_q, hold_full_d;
  logic             xfer, take_hold, set_uf;
  logic [BITS-1:0]  ramp_q;
  logic             phase_q;

  assign xfer       = s_valid & s_ready;
  assign lane_clear = (state_d == IDLE);

  // Next state and bit counter; a frame always runs to its last bit before en is honoured.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = RUN;
          bit_cnt_d = '0;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          if (en) load    = 1'b1;
          else    state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          shift     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word for the next frame, chosen by the mode present at the load.
  always_comb begin
    frame_word = last_q;
    take_hold  = 1'b0;
    set_uf     = 1'b0;
    case (ad9228_mode_e'(mode))
      NORMAL: begin
        if (hold_full_q) begin
          frame_word = hold_q;
          take_hold  = load;
        end else begin
          set_uf = load;
        end
      end
      MIDSCALE: frame_word = {NUM_CHANNELS{PAT_MID}};
      CHECKER:  frame_word = {NUM_CHANNELS{phase_q ? PAT_B : PAT_A}};
      RAMP:     frame_word = {NUM_CHANNELS{ramp_q}};
      default:  ;
    endcase
  end

  // Hold occupancy: filled by a transfer, emptied only by a normal-mode load.
  always_comb begin
    hold_full_d = hold_full_q;
    if (xfer)           hold_full_d = 1'b1;
    else if (take_hold) hold_full_d = 1'b0;
  end

  // Hold data register; accepted words wait here until the next frame boundary.
  // NOTE: the data is deliberately not reset; hold_full_q qualifies it, so
  // stale contents are never observed.
  always_ff @(posedge clk) begin
    if (xfer) hold_q <= s_data;
  end

  // Control state, pattern generators and registered frame-timing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      ramp_q      <= '0;
      phase_q     <= 1'b0;
      underflow   <= 1'b0;
      s_ready     <= 1'b0;
      fco         <= 1'b0;
      dco         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_full_q <= hold_full_d;
      s_ready     <= ~hold_full_d;
      if (take_hold) last_q <= hold_q;
      if (load && (mode == CHECKER)) phase_q <= ~phase_q;
      if (load && (mode == RAMP))    ramp_q  <= ramp_q + BITS'(1);
      // Entering RUN restarts the sticky flag; an empty-hold load in that
      // same frame still reports itself.
      if (load) underflow <= set_uf | ((state_q == RUN) & underflow);
      fco         <= (state_d == RUN) && (bit_cnt_d < HALF_BIT);
      dco         <= (state_d == RUN) && bit_cnt_d[0];
      frame_start <= load;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    ad9228_lane_ser #(
      .BITS      (BITS),
      .LSB_FIRST (LSB_FIRST)
    ) u_ser (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .clear (lane_clear),
      .data  (frame_word[c*BITS +: BITS]),
      .dout  (din[c])
    );
  end

endmodule
